// File: rtl/demux_deser8_if.sv
// Serial-in / byte-out bundle for the 8:1 deserialiser.
// master: the transmitter plus the byte-wide consumer.
// slave:  the deserialiser itself.
interface demux_deser8_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3
);
    logic             din;
    logic             din_valid;
    logic             sync;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;

    modport master (
        output din,
        output din_valid,
        output sync,
        output dout_ready,
        input  sel,
        input  dout,
        input  dout_valid,
        input  overrun
    );

    modport slave (
        input  din,
        input  din_valid,
        input  sync,
        input  dout_ready,
        output sel,
        output dout,
        output dout_valid,
        output overrun
    );
endinterface

// File: rtl/demux_deser8.sv
// Receive-side 1:8 demultiplexer.
// Each qualified serial bit is written into the slot addressed by a
// free-running select count. A completed word is offered on a
// valid/ready holding register. Words that arrive while the holding
// register is still full are dropped, and a sticky overrun flag is set.
// Every output comes straight from a flop.
module demux_deser8 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_W     = 3,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    demux_deser8_if.slave  bus
);

    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SLOT_HEAD = LSB_FIRST ? '0 : SEL_LAST;

    logic [SEL_W-1:0] sel_q,  sel_d;
    logic [WIDTH-1:0] asm_q,  asm_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q,   dv_d;
    logic             ovr_q,  ovr_d;

    logic [SEL_W-1:0] slot;
    logic             complete;
    logic [WIDTH-1:0] word;

    // Assembly path: slot write, select advance, resync and word completion.
    always_comb begin
        sel_d    = sel_q;
        asm_d    = asm_q;
        complete = 1'b0;
        word     = '0;
        slot     = LSB_FIRST ? sel_q : (SEL_LAST - sel_q);

        if (bus.sync) begin
            // Resync always restarts the frame. A bit on the same edge
            // becomes bit zero of the new word, so a completion that was
            // pending on this edge is abandoned.
            asm_d = '0;
            sel_d = '0;
            if (bus.din_valid) begin
                asm_d[SLOT_HEAD] = bus.din;
                if (WIDTH == 1) begin
                    complete = 1'b1;
                    word     = asm_d;
                end else begin
                    sel_d = SEL_W'(1);
                end
            end
        end else if (bus.din_valid) begin
            asm_d[slot] = bus.din;
            if (sel_q == SEL_LAST) begin
                complete = 1'b1;
                word     = asm_d;
                sel_d    = '0;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    // Holding register: load, replace-on-consume, drop-on-full, plain consume.
    always_comb begin
        dout_d = dout_q;
        dv_d   = dv_q;
        ovr_d  = ovr_q;

        if (complete) begin
            if (!dv_q || bus.dout_ready) begin
                dout_d = word;
                dv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dv_q && bus.dout_ready) begin
            dv_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            asm_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            asm_q  <= asm_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_demux_deser8.sv
// Bench for demux_deser8: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the receiver.
module tb_demux_deser8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_deser8_if #(.WIDTH(8), .SEL_W(3)) bif ();

    demux_deser8 #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: bits received in the current frame, in arrival order.
    bit         m_bits[$];
    logic [7:0] m_dout;
    bit         m_valid;
    bit         m_ovr;

    // Arrival order k goes to bit k of the word (LSB first).
    function automatic logic [7:0] pack_word();
        logic [7:0] w = '0;
        for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        assert (act === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit d, input bit v, input bit s, input bit rdy);
        bit         done = 1'b0;
        logic [7:0] w    = '0;
        if (r) begin
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        if (s) begin
            m_bits.delete();
            if (v) m_bits.push_back(d);
        end else if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                w    = pack_word();
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_dout  = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: apply inputs, advance model, compare all outputs 1 time unit after the edge.
    task automatic cycle(input bit r, input bit d, input bit v, input bit s, input bit rdy);
        rst            = r;
        bif.din        = d;
        bif.din_valid  = v;
        bif.sync       = s;
        bif.dout_ready = rdy;
        @(posedge clk);
        model_edge(r, d, v, s, rdy);
        #1;
        check("sel",        32'(bif.sel),        32'(m_bits.size()));
        check("dout",       32'(bif.dout),       32'(m_dout));
        check("dout_valid", 32'(bif.dout_valid), 32'(m_valid));
        check("overrun",    32'(bif.overrun),    32'(m_ovr));
    endtask

    // Send bits of b LSB first; last_rdy is dout_ready on the final bit.
    task automatic send_byte(input logic [7:0] b, input bit rdy, input bit last_rdy, input bit gapped);
        for (int i = 0; i < 8; i++) begin
            if (gapped) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
            cycle(1'b0, b[i], 1'b1, 1'b0, (i == 7) ? last_rdy : rdy);
        end
    endtask

    initial begin
        logic [7:0] tmp;
        rst            = 1'b1;
        bif.din        = 1'b0;
        bif.din_valid  = 1'b0;
        bif.sync       = 1'b0;
        bif.dout_ready = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_sel",  32'(bif.sel), 32'd0);
        check("rst_dout", 32'(bif.dout), 32'd0);

        // Basic byte 8'hBB
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'hBB, 1'b1, 1'b1, 1'b0);
        check("basic_dout",  32'(bif.dout), 32'hBB);
        check("basic_valid", 32'(bif.dout_valid), 32'd1);
        check("basic_sel",   32'(bif.sel), 32'd0);
        check("basic_ovr",   32'(bif.overrun), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("basic_one_cycle", 32'(bif.dout_valid), 32'd0);

        // Gapped input
        send_byte(8'hBB, 1'b1, 1'b1, 1'b1);
        check("gap_dout", 32'(bif.dout), 32'hBB);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back with backpressure
        send_byte(8'hBB, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        check("bp_dout", 32'(bif.dout), 32'hBB);
        check("bp_ovr",  32'(bif.overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_drain", 32'(bif.dout_valid), 32'd0);
        check("bp_sticky", 32'(bif.overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous consume and complete
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b1, 1'b0);
        check("swap_dout",  32'(bif.dout), 32'h3C);
        check("swap_valid", 32'(bif.dout_valid), 32'd1);
        check("swap_ovr",   32'(bif.overrun), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Resync mid-word
        tmp = 8'h5A;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, tmp[0], 1'b1, 1'b1, 1'b0);
        check("resync_sel", 32'(bif.sel), 32'd1);
        for (int i = 1; i < 8; i++) cycle(1'b0, tmp[i], 1'b1, 1'b0, 1'b0);
        check("resync_dout", 32'(bif.dout), 32'h5A);
        check("resync_valid", 32'(bif.dout_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word, then a clean byte
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rstmid_sel",   32'(bif.sel), 32'd0);
        check("rstmid_dout",  32'(bif.dout), 32'd0);
        check("rstmid_valid", 32'(bif.dout_valid), 32'd0);
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        check("rstmid_next", 32'(bif.dout), 32'hA5);

        // Sync on the final-bit edge suppresses completion
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("sync_last_valid", 32'(bif.dout_valid), 32'd0);
        check("sync_last_sel",   32'(bif.sel), 32'd1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Receive-side counterpart of the 8:1 select mux, which serialises a parallel byte onto one line as its select index counts 0..7.
- This block accepts that serial bit stream one bit per qualified cycle.
- It demultiplexes each bit into the slot addressed by an internal 3-bit select counter and presents the rebuilt byte on a valid/ready output holding register.
- It sits at the far end of the serial link, ahead of any byte-wide consumer.

Parameters:
- WIDTH, 8: bits per word; equals the number of mux inputs.
- SEL_W, 3: select counter width; must equal clog2(WIDTH).
- LSB_FIRST, 1: 1 = first received bit lands in dout[0]; 0 = first received bit lands in dout[WIDTH-1].

Ports:
- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  synchronous reset, active-high.
- din  in  1  serial data bit (the mux output D).
- din_valid  in  1  din is sampled on this edge.
- sync  in  1  frame marker: restarts word assembly.
- sel  out  SEL_W  current select index (the slot the next bit will be written to).
- dout  out  WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout this edge.
- overrun  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst=1 at an edge): sel=0, assembly register=0, dout=0, dout_valid=0, overrun=0. Reset takes priority over every other input, mid-word included; the partial word is discarded.
- Slot mapping: slot = sel when LSB_FIRST=1, otherwise WIDTH-1-sel.
- Capture (din_valid=1, sync=0):
  - assembly[slot] <= din; all other slots hold.
  - sel <= sel+1, wrapping from WIDTH-1 to 0.
- Cycles with din_valid=0: no state change in the assembly path.
- Word completion: a capture with sel==WIDTH-1.
  - The word built from the assembly register plus this final bit is the completed word.
  - Latency: the completed word is offered to dout at the same edge as the final bit's capture, so dout_valid=1 is visible in the cycle after the last bit was sampled.
- Output register update at the completion edge, three cases:
  - dout_valid=0: dout <= word; dout_valid <= 1.
  - dout_valid=1 and dout_ready=1: old word is consumed; dout <= new word; dout_valid stays 1; no overrun.
  - dout_valid=1 and dout_ready=0: new word dropped; dout and dout_valid unchanged; overrun <= 1.
- Consumption without completion: dout_valid=1 and dout_ready=1 clears dout_valid. dout keeps its last value.
- dout_ready while dout_valid=0 has no effect.
- overrun is sticky and is cleared only by rst.
- sync=1, din_valid=0: sel <= 0; assembly register <= 0. The output register is unaffected.
- sync=1, din_valid=1: assembly register is cleared and din is written into the slot for sel=0. sel <= 1.
  - Exception, WIDTH=1: this is a completion; sel <= 0.
- sync on the edge where sel==WIDTH-1 overrides completion. No word is produced.
- No combinational path from din, din_valid or sync to any output. All outputs are registered.
- sel is exported so a bench can check lockstep with the transmitter's select count.

Test Plan:
- Basic byte, LSB_FIRST=1: after rst, pulse sync, then 8 consecutive din_valid cycles with din = 1,1,0,1,1,1,0,1 (source byte 8'b10111011), dout_ready=1 → one cycle after the 8th bit: dout=8'hBB, dout_valid=1 for exactly one cycle, sel=0, overrun=0.
- Gapped input: the same 8 bits with din_valid low on alternate cycles → identical dout=8'hBB. sel advances only on valid cycles (0..7, then 0).
- Back-to-back with backpressure: dout_ready=0; send 8'hBB then 8'h3C → dout stays 8'hBB, dout_valid=1, overrun=1 after the second completion. Raise dout_ready → dout_valid=0 next cycle; overrun stays 1 until rst.
- Simultaneous consume and complete: dout holds 8'hBB, valid; the last bit of 8'h3C arrives with dout_ready=1 → dout=8'h3C, dout_valid stays 1, overrun=0.
- Resync mid-word: 5 bits received, then sync with din_valid=1, din=0, followed by 7 bits giving 8'h5A → sel=1 after the sync edge. Exactly one word is output, dout=8'h5A.
- Reset mid-word: 4 bits in, rst=1 for one cycle → sel=0, dout=0, dout_valid=0, overrun=0. A following full byte 8'hA5 is received correctly.
